// File: rtl/ln_stream_norm.sv
// Streaming LayerNorm over N-element signed vectors, P lanes per beat.
// Collect sums, take an exact N*std by bit-serial sqrt, invert it bit-serially, then drain.
module ln_stream_norm #(
  parameter int unsigned DW       = 16,
  parameter int unsigned N        = 64,
  parameter int unsigned P        = 8,
  parameter int unsigned OUT_FRAC = 6,
  parameter int unsigned RECIP_SH = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [P*DW-1:0] i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [P*DW-1:0] o_data,
  output logic            o_last,
  output logic            o_zero_var
);

  localparam int unsigned LOG2N   = $clog2(N);
  localparam int unsigned BEATS   = N / P;
  localparam int unsigned BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SW      = DW + LOG2N;
  localparam int unsigned QW      = 2 * DW + LOG2N;
  localparam int unsigned DDW     = 2 * DW + 2 * LOG2N;
  localparam int unsigned K       = DW + LOG2N;
  localparam int unsigned RW      = RECIP_SH + 1;
  localparam int unsigned SH      = RECIP_SH - OUT_FRAC;
  localparam int unsigned XW      = SW + 1;
  localparam int unsigned PW      = XW + RW + 2;
  localparam int unsigned STEPMAX = (K > RW) ? K : RW;
  localparam int unsigned CW      = $clog2(STEPMAX + 1);

  localparam logic signed [PW-1:0] RND  = {{(PW - SH){1'b0}}, 1'b1, {(SH - 1){1'b0}}};
  localparam logic signed [PW-1:0] YMAX = {{(PW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW-1:0] YMIN = {{(PW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    StCollect,
    StSetup,
    StSqrt,
    StRecip,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [P*DW-1:0] buf_q [BEATS];
  logic [BW-1:0]   beat_q;
  logic [SW-1:0]   s_q;
  logic [QW-1:0]   q_q;
  logic [DDW-1:0]  d_q;
  logic [K-1:0]    rem_q;
  logic [K-1:0]    root_q;
  logic [K-1:0]    dv_rem_q;
  logic [RW-1:0]   recip_q;
  logic [CW-1:0]   step_q;
  logic            zero_var_q;

  logic in_fire, out_fire, last_beat, sqrt_last, recip_last;

  assign o_ready    = i_rst & i_en & (state_q == StCollect);
  assign o_valid    = i_rst & i_en & (state_q == StDrain);
  assign in_fire    = o_ready & i_valid;
  assign out_fire   = o_valid & i_ready;
  assign last_beat  = (beat_q == BW'(BEATS - 1));
  assign sqrt_last  = (step_q == CW'(K - 1));
  assign recip_last = (step_q == CW'(RW - 1));

  // Per-beat lane sum and sum of squares
  logic [SW-1:0]   beat_sum;
  logic [QW-1:0]   beat_sq;
  logic [DW-1:0]   lane_x;
  logic [2*DW-1:0] lane_se;
  logic [2*DW-1:0] lane_sq;

  always_comb begin
    beat_sum = '0;
    beat_sq  = '0;
    lane_x   = '0;
    lane_se  = '0;
    lane_sq  = '0;
    for (int k = 0; k < P; k++) begin
      lane_x   = i_data[k*DW +: DW];
      lane_se  = {{DW{lane_x[DW-1]}}, lane_x};
      lane_sq  = lane_se * lane_se;
      beat_sum = beat_sum + {{(SW - DW){lane_x[DW-1]}}, lane_x};
      beat_sq  = beat_sq + {{(QW - 2 * DW){1'b0}}, lane_sq};
    end
  end

  // N*Q - S^2; low DDW bits of the two's complement square are exact
  logic [DDW-1:0] s_wide, s_sq, d_val;
  assign s_wide = {{(DDW - SW){s_q[SW-1]}}, s_q};
  assign s_sq   = s_wide * s_wide;
  assign d_val  = {q_q, {LOG2N{1'b0}}} - s_sq;

  // Restoring sqrt: two radicand bits in, one root bit out per step
  logic [K+1:0] sq_shift, sq_trial;
  logic         sq_take;
  assign sq_shift = {rem_q, d_q[DDW-1 -: 2]};
  assign sq_trial = {root_q, 2'b01};
  assign sq_take  = (sq_shift >= sq_trial);

  // Restoring divide of 2^RECIP_SH by root; dividend has a single 1 at its MSB
  logic [K:0] dv_shift;
  logic       dv_take;
  assign dv_shift = {dv_rem_q, (step_q == '0)};
  assign dv_take  = (root_q != '0) && (dv_shift >= {1'b0, root_q});

  always_comb begin
    state_d = state_q;
    if (i_en) begin
      unique case (state_q)
        StCollect: if (in_fire && last_beat) state_d = StSetup;
        StSetup:   state_d = StSqrt;
        StSqrt:    if (sqrt_last) state_d = StRecip;
        StRecip:   if (recip_last) state_d = StDrain;
        StDrain:   if (out_fire && last_beat) state_d = StCollect;
        default:   state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= StCollect;
    else        state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (in_fire) buf_q[beat_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      beat_q     <= '0;
      s_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      dv_rem_q   <= '0;
      recip_q    <= '0;
      step_q     <= '0;
      zero_var_q <= 1'b0;
    end else if (i_en) begin
      unique case (state_q)
        StCollect: begin
          if (in_fire) begin
            s_q    <= s_q + beat_sum;
            q_q    <= q_q + beat_sq;
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
          end
        end
        StSetup: begin
          d_q    <= d_val;
          rem_q  <= '0;
          root_q <= '0;
          step_q <= '0;
        end
        StSqrt: begin
          d_q    <= d_q << 2;
          rem_q  <= sq_take ? K'(sq_shift - sq_trial) : K'(sq_shift);
          root_q <= {root_q[K-2:0], sq_take};
          step_q <= sqrt_last ? '0 : step_q + 1'b1;
          if (sqrt_last) begin
            dv_rem_q <= '0;
            recip_q  <= '0;
          end
        end
        StRecip: begin
          dv_rem_q   <= dv_take ? K'(dv_shift - {1'b0, root_q}) : dv_shift[K-1:0];
          recip_q    <= {recip_q[RW-2:0], dv_take};
          step_q     <= recip_last ? '0 : step_q + 1'b1;
          zero_var_q <= (root_q == '0);
        end
        StDrain: begin
          if (out_fire) begin
            if (last_beat) begin
              beat_q     <= '0;
              s_q        <= '0;
              q_q        <= '0;
              step_q     <= '0;
              zero_var_q <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // y = sat(((N*x - S) * R + 2^(SH-1)) >>> SH), purely from registered state
  logic [P*DW-1:0]        row, y_data;
  logic [DW-1:0]          dr_x;
  logic [XW-1:0]          dr_nx;
  logic signed [PW-1:0]   dr_diff, dr_rcp, dr_prod, dr_y;

  assign row    = buf_q[beat_q];
  assign dr_rcp = {{(PW - RW){1'b0}}, recip_q};

  always_comb begin
    y_data  = '0;
    dr_x    = '0;
    dr_nx   = '0;
    dr_diff = '0;
    dr_prod = '0;
    dr_y    = '0;
    for (int k = 0; k < P; k++) begin
      dr_x    = row[k*DW +: DW];
      dr_nx   = {dr_x[DW-1], dr_x, {LOG2N{1'b0}}} - {s_q[SW-1], s_q};
      dr_diff = {{(PW - XW){dr_nx[XW-1]}}, dr_nx};
      dr_prod = dr_diff * dr_rcp + RND;
      dr_y    = dr_prod >>> SH;
      if (dr_y > YMAX)      y_data[k*DW +: DW] = {1'b0, {(DW - 1){1'b1}}};
      else if (dr_y < YMIN) y_data[k*DW +: DW] = {1'b1, {(DW - 1){1'b0}}};
      else                  y_data[k*DW +: DW] = dr_y[DW-1:0];
    end
  end

  assign o_data     = o_valid ? y_data : '0;
  assign o_last     = o_valid & last_beat;
  assign o_zero_var = zero_var_q;

endmodule

// File: doc/ln_stream_norm.md
# ln_stream_norm

Parametrised, streaming LayerNorm core for signed fixed-point vectors of N elements, delivered P lanes per beat with valid/ready on both sides. It collects one vector while accumulating Σx and Σx², computes an exact integer N·std with a bit-serial square root, forms a reciprocal with a bit-serial divider, then streams out normalised elements in Q(OUT_FRAC). It replaces the fixed 64×16-bit LayerNorm top in the normalisation path, adding chunked input, backpressure, and a zero-variance flag.

## Interface
- DW, 16: element width, signed.
- N, 64: vector length; power of two, ≥ 2; LOG2N = log2(N).
- P, 8: lanes per beat; divides N; BEATS = N/P.
- OUT_FRAC, 6: fractional bits of the output.
- RECIP_SH, 32: reciprocal scale; requires RECIP_SH > OUT_FRAC.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_en  in  1  global enable. When 0, all state holds and o_ready = o_valid = 0.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid & o_ready.
- i_data  in  P*DW  lane k at [k*DW +: DW]; beat b carries elements b*P..b*P+P-1.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  P*DW  normalised lanes, same packing as i_data.
- o_last  out  1  marks the final beat of a vector; qualified by o_valid.
- o_zero_var  out  1  vector had zero variance; constant during DRAIN.

## Operation
- FSM states:
  - COLLECT → (last beat accepted) SETUP → SQRT → RECIP → DRAIN → (last beat accepted) COLLECT.
  - There is no overlap between vectors: o_ready = 1 only in COLLECT.
- COLLECT:
  - On each accepted beat, write the beat to buffer[beat_cnt].
  - Accumulate S += Σ lanes and Q += Σ lanes².
  - S width is DW+LOG2N; Q width is 2·DW+LOG2N.
  - beat_cnt counts 0..BEATS-1.
- SETUP (1 cycle): register D = N·Q − S². D is ≥ 0 by construction; width 2·DW+2·LOG2N.
- SQRT (K = DW+LOG2N cycles): restoring integer square root, one result bit per cycle, giving r = floor(√D).
- RECIP (RECIP_SH+1 cycles): restoring division, one quotient bit per cycle.
  - R = floor(2^RECIP_SH / r).
  - If r = 0, then R = 0 and o_zero_var is set. The division still runs its full cycle count, so latency is constant.
- DRAIN: beat index d = 0..BEATS-1. For each lane x, y = sat_DW((((N·x − S)·R) + 2^(SH−1)) >>> SH), where SH = RECIP_SH − OUT_FRAC.
  - Rounding is round-half-up.
  - Saturation clamps to [−2^(DW−1), 2^(DW−1)−1].
  - y is combinational from registered state, so it is stable while stalled.
  - o_last = (d == BEATS−1).
- On the last DRAIN handshake: clear S, Q, counters and o_zero_var, then return to COLLECT.

## Timing
- Reset (i_rst = 0 at an edge): state = COLLECT; S, Q, D, r, R and counters = 0; o_zero_var = 0.
- Output values:
  - o_ready is 0 while i_rst = 0, and 1 from the first cycle after reset.
  - o_valid = 0 and o_last = 0 outside DRAIN.
  - o_data = 0 whenever o_valid = 0.
- Reset mid-operation aborts the vector. Partial input is discarded and no output beats are emitted for it.
- Latency: o_valid first rises in the cycle after L = 3 + DW + LOG2N + RECIP_SH enabled edges, counted from the edge that accepted the last input beat. The default is 57.
- Cycles with i_en = 0 extend the latency one-for-one.
- Handshake rules:
  - o_valid stays high and o_data/o_last stay stable until i_ready.
  - An i_valid beat while o_ready = 0 is not consumed; the source must hold it.
- Input bubbles (i_valid = 0) and output stalls are legal in any cycle.
- Throughput: one vector per BEATS + L + BEATS cycles minimum.

## Test plan
- Constant vector, all elements 37 → all 64 outputs 0; o_zero_var = 1; 8 output beats; o_last on beat 8 only.
- Alternating vector, x_k = +100 for even k and −100 for odd k → D = 40960000, r = 6400, R = 671088; outputs +64 / −64 alternating; o_zero_var = 0.
- Ramp x_k = k − 32 → S = −32, D = 1397760, r = 1182, R = 3633644; y_0 = −109, y_63 = 109; full vector matches the exact integer formula bit-for-bit.
- OUT_FRAC = 13, x_0 = 30000, all other elements 0 → y_0 saturates to 32767; y_1..63 = −1032 ±1 (per the integer formula).
- Backpressure: i_valid asserted every other cycle during COLLECT, i_ready toggling during DRAIN → same results as the alternating test.
  - o_data holds across stalls.
  - o_ready = 0 from SETUP through DRAIN.
  - o_valid rises exactly 57 edges after the last input accept.
- Control: i_en = 0 for 10 cycles during SQRT → o_valid delayed by exactly 10 cycles.
  - Then i_rst = 0 for 1 cycle in DRAIN beat 3 → next cycle o_valid = 0 and o_ready = 1.
  - A fresh ramp vector afterwards produces the correct results.
